adc_word_sequencer: RTL and testbench

Multi-cycle, multi-word add-with-carry engine. A WORDS×WIDTH-bit addition (A + B + CIN) is computed as a sequence of WIDTH-bit add-with-carry slices, one slice per clock, least-significant first, with the carry registered between slices. Operands and results move over valid/ready handshakes. The block lets a narrow adc datapath (the 3-bit I0/I1/CIN → O/COUT adder) serve wide operands without widening the adder.

---
 rtl/adc_word_sequencer.sv | 133 +++++++++++++
 tb/tb_adc_word_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_word_sequencer.sv
// Wide add-with-carry built from a WIDTH-bit adder slice, one slice per clock,
// least-significant first, with the carry held in a register between slices.
module adc_word_sequencer #(
  parameter int WIDTH = 3,
  parameter int WORDS = 4,
  localparam int N     = WIDTH * WORDS,
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic         CLK,
  input  logic         ASYNCRESETN,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         CIN,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] O,
  output logic         COUT,
  output logic         busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;
  logic [N-1:0]     a_r;
  logic [N-1:0]     b_r;
  logic [N-1:0]     o_r;
  logic             cout_r;
  logic [WIDTH-1:0] a_slice_s;
  logic [WIDTH-1:0] b_slice_s;
  logic [WIDTH:0]   sum_s;
  logic             idx_last_s;

  // Current slice operands and the narrow adder itself.
  always_comb begin
    a_slice_s  = a_r[32'(idx_r) * WIDTH +: WIDTH];
    b_slice_s  = b_r[32'(idx_r) * WIDTH +: WIDTH];
    sum_s      = {1'b0, a_slice_s} + {1'b0, b_slice_s} + {{WIDTH{1'b0}}, carry_r};
    idx_last_s = (idx_r == IDX_W'(WORDS - 1));
  end

  // Next-state decode for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (idx_last_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Operand capture, slice write-back and carry chaining; reset wipes any partial result.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      idx_r   <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      o_r     <= '0;
      cout_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r     <= A;
            b_r     <= B;
            carry_r <= CIN;
            idx_r   <= '0;
          end
        end
        ST_RUN: begin
          o_r[32'(idx_r) * WIDTH +: WIDTH] <= sum_s[WIDTH-1:0];
          carry_r <= sum_s[WIDTH];
          // Index saturates at the last slice; the FSM leaves RUN on that edge.
          if (idx_last_s) begin
            cout_r <= sum_s[WIDTH];
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        ST_DONE: begin
          cout_r <= cout_r;
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign busy      = (state_r == ST_RUN) || (state_r == ST_DONE);
  assign O         = o_r;
  assign COUT      = cout_r;

endmodule

// File: tb/tb_adc_word_sequencer.sv
// Scoreboard bench for adc_word_sequencer (WIDTH=3, WORDS=4): expected sums come
// from plain integer addition and are checked by a monitor on each result handshake.
module tb_adc_word_sequencer;

  localparam int WIDTH = 3;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;

  logic         CLK = 1'b0;
  logic         ASYNCRESETN = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         CIN = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] O;
  logic         COUT;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;  // 0 random, 1 hold low, 2 hold high
  logic [N:0] sb[$];

  adc_word_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .CIN(CIN),
    .out_valid(out_valid), .out_ready(out_ready),
    .O(O), .COUT(COUT), .busy(busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
    int unsigned s;
    s = int'(a) + int'(b) + int'(cin);
    return s[N:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer-side ready generation.
  always begin
    @(posedge CLK);
    #1;
    case (ready_mode)
      0: out_ready = 1'($urandom_range(0, 1));
      1: out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: every result handshake pops one expected {COUT,O}.
  always @(negedge CLK) begin
    if (ASYNCRESETN && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got 0x%0h with empty scoreboard", {COUT, O});
      end else begin
        check("result", 32'({COUT, O}), 32'(sb.pop_front()));
      end
    end
  end

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin, input logic [N:0] exp);
    int n;
    A = a; B = b; CIN = cin; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge CLK);
      if (in_ready) break;
      n++;
      if (n > 300) begin
        check("accept_timeout", 32'(n), 32'(0));
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    sb.push_back(exp);
    A = N'($urandom); B = N'($urandom); CIN = 1'($urandom);
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    forever begin
      @(posedge CLK);
      #1;
      n++;
      if (out_valid || n > 50) break;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 500) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("drain", 32'(sb.size()), 32'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_O"}, 32'(O), 32'(0));
    check({tag, "_COUT"}, 32'(COUT), 32'(0));
    check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge CLK);
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    check_reset_outputs(tag);
    sb.delete();
    #1;
    ASYNCRESETN = 1'b1;
  endtask

  initial begin
    int n;
    logic [N-1:0] ra, rb;
    logic rc;

    // Reset asserted between edges, before any clock edge has occurred.
    #1 ASYNCRESETN = 1'b0;
    #1 check_reset_outputs("reset_initial");
    #10 ASYNCRESETN = 1'b1;
    @(posedge CLK);
    #1;

    // Simple add with latency check.
    ready_mode = 0;
    send(12'h005, 12'h003, 1'b0, 13'h0008);
    check("busy_in_run", 32'(busy), 32'(1));
    check("in_ready_in_run", 32'(in_ready), 32'(0));
    wait_out_valid(n);
    check("latency_edges", 32'(n), 32'(WORDS));
    drain();

    // Full carry ripple and maximum operands.
    send(12'hFFF, 12'h000, 1'b1, 13'h1000);
    send(12'hFFF, 12'hFFF, 1'b1, 13'h1FFF);
    send(12'h924, 12'h492, 1'b0, 13'h0DB6);
    drain();

    // Backpressure: result and flags hold while new operands are offered.
    ready_mode = 1;
    send(12'h7A5, 12'h3C3, 1'b1, model(12'h7A5, 12'h3C3, 1'b1));
    wait_out_valid(n);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      A = N'($urandom); B = N'($urandom); CIN = 1'($urandom);
      @(posedge CLK);
      #1;
      check("bp_out_valid", 32'(out_valid), 32'(1));
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_hold", 32'({COUT, O}), 32'(model(12'h7A5, 12'h3C3, 1'b1)));
    end
    in_valid = 1'b0;
    ready_mode = 2;
    n = 0;
    do begin
      @(posedge CLK);
      #2;
      n++;
    end while (out_valid && n < 10);
    check("bp_release_cycles", 32'(n), 32'(2));
    check("bp_idle_in_ready", 32'(in_ready), 32'(1));
    check("bp_idle_busy", 32'(busy), 32'(0));
    check("bp_consumed", 32'(sb.size()), 32'(0));

    // Reset while holding a result in DONE.
    ready_mode = 1;
    send(12'hFFF, 12'hFFF, 1'b1, 13'h1FFF);
    wait_out_valid(n);
    pulse_reset("reset_in_done");

    // Reset mid-operation, then a fresh operation.
    send(12'hFFF, 12'h001, 1'b0, 13'h1000);
    @(posedge CLK);
    pulse_reset("reset_mid_run");
    ready_mode = 0;
    send(12'h123, 12'h456, 1'b1, 13'h057A);
    drain();

    // Randomized operations under random consumer backpressure.
    for (int i = 0; i < 40; i++) begin
      ra = N'($urandom); rb = N'($urandom); rc = 1'($urandom);
      send(ra, rb, rc, model(ra, rb, rc));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
